// File: rtl/neuron_arith_pkg.sv
// Shared arithmetic types and helpers for the neuron core's serial datapaths.
// Provides the serial-subtractor state encoding and a 1-bit full-subtract function.
package neuron_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Returns {difference, borrow_out} for a single bit position.
    function automatic logic [1:0] full_sub(
        input logic a,
        input logic b,
        input logic bin
    );
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {d, bout};
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
// Ports: a, b, bin (inputs); d, bout (outputs).
module fs_cell
    import neuron_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign {d, bout} = full_sub(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH shift cycles.
// Ports: clk, rst (sync, active high), start, a, b, bin in; busy, ser_bit,
// ser_valid, diff, borrow, done out.
module serial_subtractor
    import neuron_arith_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t     state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

    fs_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            res       <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            done      <= 1'b0;
        end else begin
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        res   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ser_bit   <= d;
                    ser_valid <= 1'b1;
                    // LSB-first: after WIDTH shifts the first bit sits at bit 0
                    res       <= {d, res[WIDTH-1:1]};
                    sa        <= sa >> 1;
                    sb        <= sb >> 1;
                    br        <= bout;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    diff   <= (SATURATE && br) ? '0 : res;
                    borrow <= br;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing D = A − B − Bin over WIDTH cycles.
- Built around one full-subtractor cell and a borrow flip-flop. It is the inverse-direction counterpart of the team's full-adder datapath.
- Used in the neuron core for membrane-potential leak and threshold compare: potential − leak, or potential − threshold, where the final borrow means "below".
- Digital-side block: logic ports, not xreal.

Parameters:
- WIDTH, 8: operand and result width in bits, ≥ 2.
- SATURATE, 0: when 1, a result that underflows (final borrow = 1) is clamped to 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  minuend, sampled on accepted start
- b  input  WIDTH  subtrahend, sampled on accepted start
- bin  input  1  borrow-in, sampled on accepted start
- busy  output  1  high in SHIFT and DONE
- ser_bit  output  1  difference bit produced this cycle
- ser_valid  output  1  high for each of the WIDTH SHIFT cycles
- diff  output  WIDTH  final result, held until the next accepted start or reset
- borrow  output  1  final borrow-out (underflow / A<B flag), held the same way as diff
- done  output  1  one-cycle pulse when diff and borrow become valid

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: busy, ser_bit, ser_valid, diff, borrow, done.
  - Internal shift registers, borrow FF and counter cleared.
  - Reset mid-operation aborts without producing done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load sa=a, sb=b, br=bin, cnt=0; clear the result shift register; go to SHIFT.
  - diff and borrow keep their previous values until DONE overwrites them.
- SHIFT, each cycle:
  - d = sa[0]^sb[0]^br
  - br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - ser_bit=d and ser_valid=1, registered and aligned with this SHIFT cycle.
  - Result register shifts right, with d entering at the MSB.
  - sa and sb shift right.
  - cnt increments.
  - After the WIDTH-th bit (cnt==WIDTH−1) → DONE.
- DONE, one cycle:
  - diff = result register, or 0 if SATURATE==1 and the final br==1.
  - borrow = final br, regardless of SATURATE.
  - done=1 for exactly this cycle, then → IDLE.
- Latency: start sampled at edge 0 → ser_valid high on edges 1..WIDTH → done high after edge WIDTH+1. Total WIDTH+1 cycles; next start accepted the cycle after done.
- start while busy (SHIFT or DONE): ignored, not queued. Operands are unaffected.
- Operand changes on a or b after acceptance have no effect.
- Simultaneous rst and start: rst wins.
- Arithmetic is modulo 2^WIDTH. Boundary cases:
  - a==b, bin=0 → 0, borrow 0
  - 0−1 → all ones, borrow 1
  - max−max → 0
- cnt width: $clog2(WIDTH). No wrap beyond WIDTH−1.

Decomposition:
- Shared package neuron_arith_pkg:
  - state enum sub_state_t {IDLE, SHIFT, DONE}
  - function full_sub(a,b,bin) returning {diff,bout}, reused by other serial blocks
- Natural sub-module: fs_cell, a combinational 1-bit full subtractor with ports a, b, bin, d, bout.
- Top level holds the FSM, shift registers, borrow FF and counter.

Test Plan:
- WIDTH=8, a=5, b=3, bin=0, start one cycle:
  - ser_bit sequence LSB-first 0,1,0,0,0,0,0,0
  - done after 9 cycles
  - diff=0x02, borrow=0
- a=3, b=5, SATURATE=0 → diff=0xFE, borrow=1. Same with SATURATE=1 → diff=0x00, borrow=1.
- Boundaries:
  - a=0x00, b=0x01 → diff=0xFF, borrow=1
  - a=0xFF, b=0xFF, bin=1 → diff=0xFF, borrow=1
  - a=0x80, b=0x00, bin=1 → diff=0x7F, borrow=0
- start=1 held continuously with changing a/b during SHIFT:
  - only the first operands are used
  - the next operation is accepted in the cycle after done
  - exactly one done per accepted start
- rst asserted on cycle 4 of SHIFT: next cycle all outputs 0, state IDLE, no done. A subsequent start of 10−4 → diff=0x06 after 9 cycles.
- Back-to-back random operands (1000 ops, WIDTH=8 and WIDTH=16) vs. reference model (a−b−bin) mod 2^WIDTH, with borrow = (a < b+bin).
